// File: rtl/iomem_bridge.sv
// iomem_bridge: slot-decoded bridge from the picosoc iomem master port to
// NUM_SLV peripheral slaves, with per-slave stall and a bus timeout.
// Optional status register enabled by defining IOMEM_BRIDGE_STATUS_EN.
module iomem_bridge #(
    parameter int          NUM_SLV   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int          SPAN_BITS = 12,
    parameter int          IDX_BITS  = 4,
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   iomem_valid,
    output logic                   iomem_ready,
    input  logic [3:0]             iomem_wstrb,
    input  logic [31:0]            iomem_addr,
    input  logic [31:0]            iomem_wdata,
    output logic [31:0]            iomem_rdata,
    output logic [NUM_SLV-1:0]     slv_valid,
    input  logic [NUM_SLV-1:0]     slv_ready,
    output logic [3:0]             slv_wstrb,
    output logic [SPAN_BITS-1:0]   slv_addr,
    output logic [31:0]            slv_wdata,
    input  logic [32*NUM_SLV-1:0]  slv_rdata
);

    localparam int TOP   = SPAN_BITS + IDX_BITS;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_BITS:0] NUM_SLV_I = (IDX_BITS + 1)'(NUM_SLV);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic                   iomem_ready_q, iomem_ready_d;
    logic [31:0]            iomem_rdata_q, iomem_rdata_d;
    logic [NUM_SLV-1:0]     slv_valid_q, slv_valid_d;
    logic [3:0]             slv_wstrb_q, slv_wstrb_d;
    logic [SPAN_BITS-1:0]   slv_addr_q, slv_addr_d;
    logic [31:0]            slv_wdata_q, slv_wdata_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   addr_hit;
    logic [IDX_BITS-1:0]    addr_idx;
    logic                   idx_mapped;
    logic                   sel_ready;
    logic [31:0]            sel_rdata;

`ifdef IOMEM_BRIDGE_STATUS_EN
    logic [IDX_BITS-1:0]    sel_q, sel_d;
    logic [15:0]            err_cnt_q, err_cnt_d;
    logic [7:0]             last_err_idx_q, last_err_idx_d;
    logic                   timeout_seen_q, timeout_seen_d;
    logic                   idx_status;
    logic                   err_evt;
    logic                   err_tmo;
    logic [IDX_BITS-1:0]    err_slot;
    logic [31:0]            status_word;

    assign idx_status  = ({1'b0, addr_idx} == NUM_SLV_I);
    assign status_word = {err_cnt_q, last_err_idx_q, 7'b0, timeout_seen_q};
`endif

    assign addr_hit   = (iomem_addr[31:TOP] == BASE_ADDR[31:TOP]);
    assign addr_idx   = iomem_addr[TOP-1:SPAN_BITS];
    assign idx_mapped = ({1'b0, addr_idx} < NUM_SLV_I);

    // slv_valid_q is one-hot, so masking with it selects the active slave's ready
    assign sel_ready = |(slv_ready & slv_valid_q);

    // Read data mux for the slave currently holding slv_valid
    always_comb begin
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            sel_rdata = sel_rdata | (slv_rdata[32*i +: 32] & {32{slv_valid_q[i]}});
        end
    end

    // Next-state and registered-output computation for the request/response FSM
    always_comb begin
        state_d       = state_q;
        iomem_ready_d = iomem_ready_q;
        iomem_rdata_d = iomem_rdata_q;
        slv_valid_d   = slv_valid_q;
        slv_wstrb_d   = slv_wstrb_q;
        slv_addr_d    = slv_addr_q;
        slv_wdata_d   = slv_wdata_q;
        cnt_d         = cnt_q;
`ifdef IOMEM_BRIDGE_STATUS_EN
        sel_d          = sel_q;
        err_cnt_d      = err_cnt_q;
        last_err_idx_d = last_err_idx_q;
        timeout_seen_d = timeout_seen_q;
        err_evt        = 1'b0;
        err_tmo        = 1'b0;
        err_slot       = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                iomem_ready_d = 1'b0;
                if (iomem_valid && !iomem_ready_q && addr_hit) begin
                    if (idx_mapped) begin
                        state_d = ST_REQ;
                        for (int unsigned i = 0; i < NUM_SLV; i++) begin
                            slv_valid_d[i] = ({1'b0, addr_idx} == (IDX_BITS + 1)'(i));
                        end
                        slv_addr_d  = iomem_addr[SPAN_BITS-1:0];
                        slv_wdata_d = iomem_wdata;
                        slv_wstrb_d = iomem_wstrb;
                        cnt_d       = '0;
`ifdef IOMEM_BRIDGE_STATUS_EN
                        sel_d       = addr_idx;
                    end else if (idx_status) begin
                        state_d       = ST_RESP;
                        iomem_ready_d = 1'b1;
                        iomem_rdata_d = status_word;
                        if (iomem_wstrb != 4'b0000) begin
                            err_cnt_d      = '0;
                            last_err_idx_d = '0;
                            timeout_seen_d = 1'b0;
                        end
`endif
                    end else begin
                        state_d       = ST_RESP;
                        iomem_ready_d = 1'b1;
                        iomem_rdata_d = ERR_DATA;
`ifdef IOMEM_BRIDGE_STATUS_EN
                        err_evt  = 1'b1;
                        err_slot = addr_idx;
`endif
                    end
                end
            end
            ST_REQ: begin
                if (sel_ready) begin
                    state_d       = ST_RESP;
                    slv_valid_d   = '0;
                    iomem_ready_d = 1'b1;
                    iomem_rdata_d = sel_rdata;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d       = ST_RESP;
                    slv_valid_d   = '0;
                    iomem_ready_d = 1'b1;
                    iomem_rdata_d = ERR_DATA;
`ifdef IOMEM_BRIDGE_STATUS_EN
                    err_evt  = 1'b1;
                    err_tmo  = 1'b1;
                    err_slot = sel_q;
`endif
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                iomem_ready_d = 1'b0;
                state_d       = ST_IDLE;
            end
            default: begin
                iomem_ready_d = 1'b0;
                slv_valid_d   = '0;
                state_d       = ST_IDLE;
            end
        endcase
`ifdef IOMEM_BRIDGE_STATUS_EN
        if (err_evt) begin
            err_cnt_d      = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
            last_err_idx_d = 8'(err_slot);
            if (err_tmo) begin
                timeout_seen_d = 1'b1;
            end
        end
`endif
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            iomem_ready_q <= 1'b0;
            iomem_rdata_q <= '0;
            slv_valid_q   <= '0;
            slv_wstrb_q   <= '0;
            slv_addr_q    <= '0;
            slv_wdata_q   <= '0;
            cnt_q         <= '0;
`ifdef IOMEM_BRIDGE_STATUS_EN
            sel_q          <= '0;
            err_cnt_q      <= '0;
            last_err_idx_q <= '0;
            timeout_seen_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            iomem_ready_q <= iomem_ready_d;
            iomem_rdata_q <= iomem_rdata_d;
            slv_valid_q   <= slv_valid_d;
            slv_wstrb_q   <= slv_wstrb_d;
            slv_addr_q    <= slv_addr_d;
            slv_wdata_q   <= slv_wdata_d;
            cnt_q         <= cnt_d;
`ifdef IOMEM_BRIDGE_STATUS_EN
            sel_q          <= sel_d;
            err_cnt_q      <= err_cnt_d;
            last_err_idx_q <= last_err_idx_d;
            timeout_seen_q <= timeout_seen_d;
`endif
        end
    end

    assign iomem_ready = iomem_ready_q;
    assign iomem_rdata = iomem_rdata_q;
    assign slv_valid   = slv_valid_q;
    assign slv_wstrb   = slv_wstrb_q;
    assign slv_addr    = slv_addr_q;
    assign slv_wdata   = slv_wdata_q;

endmodule

// File: tb/tb_iomem_bridge.sv
// Directed + randomized bench for iomem_bridge against a transaction-level
// reference model (slot decode, response cycle, response data, status fields).
module tb_iomem_bridge;

    localparam int          NUM_SLV   = 4;
    localparam logic [31:0] BASE_ADDR = 32'h0300_0000;
    localparam int          SPAN_BITS = 12;
    localparam int          IDX_BITS  = 4;
    localparam int          TIMEOUT   = 64;
    localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic                  iomem_valid;
    logic                  iomem_ready;
    logic [3:0]            iomem_wstrb;
    logic [31:0]           iomem_addr;
    logic [31:0]           iomem_wdata;
    logic [31:0]           iomem_rdata;
    logic [NUM_SLV-1:0]    slv_valid;
    logic [NUM_SLV-1:0]    slv_ready;
    logic [3:0]            slv_wstrb;
    logic [SPAN_BITS-1:0]  slv_addr;
    logic [31:0]           slv_wdata;
    logic [32*NUM_SLV-1:0] slv_rdata;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] prev_rdata;
    bit          prev_known;
    int unsigned m_err_cnt;
    int unsigned m_last;
    bit          m_tseen;

    always #5 clk = ~clk;

    iomem_bridge #(
        .NUM_SLV   (NUM_SLV),
        .BASE_ADDR (BASE_ADDR),
        .SPAN_BITS (SPAN_BITS),
        .IDX_BITS  (IDX_BITS),
        .TIMEOUT   (TIMEOUT),
        .ERR_DATA  (ERR_DATA)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .slv_valid   (slv_valid),
        .slv_ready   (slv_ready),
        .slv_wstrb   (slv_wstrb),
        .slv_addr    (slv_addr),
        .slv_wdata   (slv_wdata),
        .slv_rdata   (slv_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_err(input int unsigned slot, input bit tmo);
        m_err_cnt = (m_err_cnt == 32'd65535) ? m_err_cnt : m_err_cnt + 1;
        m_last    = slot;
        if (tmo) m_tseen = 1'b1;
    endtask

    // One master transaction; d = cycle (counted from first slv_valid cycle = 1)
    // in which the addressed slave raises ready, 0 = never.
    task automatic txn(input logic [31:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, input int d, input logic [31:0] srd);
        bit                 hit;
        int unsigned        slot;
        int                 resp;
        int                 ncyc;
        logic [31:0]        exp_data;
        bit                 chk_data;
        logic [NUM_SLV-1:0] onehot;
        logic [NUM_SLV-1:0] noise;

        hit      = ((addr >> 16) == (BASE_ADDR >> 16));
        slot     = (addr >> 12) & 32'hF;
        resp     = 0;
        exp_data = ERR_DATA;
        chk_data = 1'b1;
        onehot   = '0;
        if (!hit) begin
            resp = 0;
        end else if (slot < NUM_SLV) begin
            onehot = NUM_SLV'(1) << slot;
            if (d >= 1 && d <= TIMEOUT) begin
                resp     = d + 1;
                exp_data = srd;
            end else begin
                resp = TIMEOUT + 1;
                model_err(slot, 1'b1);
            end
`ifdef IOMEM_BRIDGE_STATUS_EN
        end else if (slot == NUM_SLV) begin
            resp = 1;
            if (wstrb != 4'b0000) begin
                chk_data  = 1'b0;
                m_err_cnt = 0;
                m_last    = 0;
                m_tseen   = 1'b0;
            end else begin
                exp_data = {m_err_cnt[15:0], m_last[7:0], 7'b0, m_tseen};
            end
`endif
        end else begin
            resp = 1;
            model_err(slot, 1'b0);
        end
        ncyc = (resp == 0) ? 100 : resp + 1;

        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = wstrb;
        iomem_wdata = wdata;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            if (resp != 0 && c == resp + 1) iomem_valid = 1'b0;
            noise     = NUM_SLV'($urandom);
            slv_ready = (noise & ~onehot) | ((c == d) ? onehot : '0);
            for (int i = 0; i < NUM_SLV; i++) begin
                slv_rdata[32*i +: 32] = (i == int'(slot)) ? srd : $urandom;
            end
            @(negedge clk);
            chk("iomem_ready", 32'(iomem_ready), 32'(c == resp));
            chk("slv_valid", 32'(slv_valid), (c < resp) ? 32'(onehot) : 32'h0);
            if (onehot != '0 && c < resp) begin
                chk("slv_addr", 32'(slv_addr), addr & 32'hFFF);
                chk("slv_wstrb", 32'(slv_wstrb), 32'(wstrb));
                chk("slv_wdata", slv_wdata, wdata);
            end
            if (c == resp) begin
                if (chk_data) chk("iomem_rdata", iomem_rdata, exp_data);
            end else if (prev_known) begin
                chk("rdata_hold", iomem_rdata, prev_rdata);
            end
            if (resp != 0 && c == resp) begin
                prev_rdata = exp_data;
                prev_known = chk_data;
            end
        end
        iomem_valid = 1'b0;
        slv_ready   = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          s;
        int          r;

        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        slv_ready   = '0;
        slv_rdata   = '0;
        m_err_cnt   = 0;
        m_last      = 0;
        m_tseen     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(iomem_ready), 32'h0);
        chk("rst_rdata", iomem_rdata, 32'h0);
        chk("rst_slv_valid", 32'(slv_valid), 32'h0);
        chk("rst_slv_wstrb", 32'(slv_wstrb), 32'h0);
        chk("rst_slv_addr", 32'(slv_addr), 32'h0);
        chk("rst_slv_wdata", slv_wdata, 32'h0);
        resetn     = 1'b1;
        prev_rdata = 32'h0;
        prev_known = 1'b1;
        @(negedge clk);

        // Directed cases
        txn(32'h0300_1004, 4'b0000, 32'h0, 3, 32'h1234_5678);
        txn(32'h0300_0000, 4'b0011, 32'hAABB_CCDD, 1, 32'h0BAD_F00D);
        txn(32'h0300_2000, 4'b0000, 32'h0, 0, 32'h5555_AAAA);
`ifdef IOMEM_BRIDGE_STATUS_EN
        txn(32'h0300_4000, 4'b0000, 32'h0, 0, 32'h0);
        txn(32'h0300_4000, 4'b1111, 32'h0, 0, 32'h0);
        txn(32'h0300_4000, 4'b0000, 32'h0, 0, 32'h0);
`endif
        txn(32'h0300_9000, 4'b0000, 32'h0, 1, 32'h0);
        txn(32'h0400_0000, 4'b0000, 32'h0, 1, 32'h0);
        txn(32'h0300_3ffc, 4'b0000, 32'h0, TIMEOUT, 32'hCAFE_0001);
        txn(32'h0300_1008, 4'b1000, 32'h1, TIMEOUT + 1, 32'hCAFE_0002);
        txn(32'h0300_f000, 4'b0000, 32'h0, 1, 32'h0);

        // Reset in the middle of a slot 3 request
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_3010;
        iomem_wstrb = 4'b0000;
        iomem_wdata = 32'h0;
        slv_ready   = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("mid_slv_valid", 32'(slv_valid), 32'h8);
        #1 resetn = 1'b0;
        #1;
        chk("abort_slv_valid", 32'(slv_valid), 32'h0);
        chk("abort_ready", 32'(iomem_ready), 32'h0);
        chk("abort_rdata", iomem_rdata, 32'h0);
        iomem_valid = 1'b0;
        m_err_cnt   = 0;
        m_last      = 0;
        m_tseen     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_held_ready", 32'(iomem_ready), 32'h0);
        resetn     = 1'b1;
        prev_rdata = 32'h0;
        prev_known = 1'b1;
        @(negedge clk);
        txn(32'h0300_3010, 4'b0000, 32'h0, 2, 32'h3333_CCCC);

        // Randomized traffic
        for (int k = 0; k < 25; k++) begin
            s = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0)
                a = 32'h0301_0000 | ($urandom & 32'hFFFF);
            else
                a = BASE_ADDR | (32'(s) << 12) | ($urandom & 32'hFFF);
            r = $urandom_range(0, 9);
            txn(a, ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)),
                $urandom, r, $urandom);
        end
`ifdef IOMEM_BRIDGE_STATUS_EN
        txn(32'h0300_4000, 4'b0000, 32'h0, 0, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/iomem_bridge.md
Name: iomem_bridge

Overview:
- Parametrised iomem peripheral bridge between the picosoc iomem master port and NUM_SLV independent peripheral slaves (gpio, RNG, user RAM, future blocks).
- Replaces hand-written per-address decode in the top level with slot-based decode, a registered request/response FSM, per-slave stall support and a bus timeout.
- Unmapped slots and unresponsive slaves return ERR_DATA instead of hanging the CPU.

Parameters:
- NUM_SLV, 4, number of slave channels (1..15).
- BASE_ADDR, 32'h0300_0000, base of bridge window; must be aligned to 2^(SPAN_BITS+IDX_BITS).
- SPAN_BITS, 12, log2 of bytes per slot (slot i at BASE_ADDR + i<<SPAN_BITS).
- IDX_BITS, 4, slot index width; window = 2^IDX_BITS slots.
- TIMEOUT, 64, cycles to wait for slv_ready; 0 = wait forever.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error/timeout.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- iomem_valid  in  1  master request
- iomem_ready  out  1  one-cycle response strobe
- iomem_wstrb  in  4  byte write strobes; 0 = read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid with iomem_ready
- slv_valid  out  NUM_SLV  one-hot request to selected slave
- slv_ready  in  NUM_SLV  per-slave completion
- slv_wstrb  out  4  registered strobes (shared)
- slv_addr  out  SPAN_BITS  registered offset within slot (shared)
- slv_wdata  out  32  registered write data (shared)
- slv_rdata  in  32*NUM_SLV  per-slave read data, slave i at [32*i+31:32*i]

Behaviour:
- Reset (async, resetn low): state IDLE; iomem_ready=0, iomem_rdata=0, slv_valid=0, slv_wstrb=0, slv_addr=0, slv_wdata=0, timeout counter=0. Reset mid-transaction aborts it; no response is issued.
- Window hit: iomem_addr[31:SPAN_BITS+IDX_BITS] == BASE_ADDR[31:SPAN_BITS+IDX_BITS]; idx = iomem_addr[SPAN_BITS+IDX_BITS-1:SPAN_BITS].
- Miss: bridge stays IDLE, never asserts iomem_ready (other decoders may answer).
- FSM IDLE -> REQ: iomem_valid && hit && idx<NUM_SLV; latch idx, slv_addr=addr[SPAN_BITS-1:0], slv_wdata, slv_wstrb; slv_valid[idx]=1 next cycle; counter cleared.
- FSM IDLE -> RESP: iomem_valid && hit && idx>=NUM_SLV (and not the status slot); rdata=ERR_DATA.
- REQ: slv_valid[idx] held high, shared outputs stable. On slv_ready[idx]: slv_valid=0, iomem_rdata=slv_rdata[idx], -> RESP. Otherwise counter++; when counter reaches TIMEOUT-1 without ready (TIMEOUT!=0): slv_valid=0, iomem_rdata=ERR_DATA, -> RESP. Ready and timeout in same cycle: ready wins.
- slv_ready of non-selected slaves ignored.
- RESP: iomem_ready=1 for exactly one cycle, -> IDLE. iomem_rdata holds until next response.
- Latency: request sampled cycle 0; slv_valid cycle 1; slave ready at cycle k>=1 -> iomem_ready at cycle k+1. Error slot: iomem_ready at cycle 1. Timeout: iomem_ready at cycle TIMEOUT+1.
- No new request accepted while in REQ/RESP; IDLE re-samples iomem_valid only while iomem_ready=0.
- Writes that time out are dropped; iomem_ready still issued.

Optional Feature:
- Macro IOMEM_BRIDGE_STATUS_EN.
- With: slot index NUM_SLV is a status register handled internally (response at cycle 1). Read returns {err_cnt[15:0], last_err_idx[7:0], 7'b0, timeout_seen}; err_cnt saturates at 16'hFFFF, counts timeouts and unmapped-slot accesses; last_err_idx = slot of latest error. Any write (wstrb!=0) clears all fields. All reset to 0. Requires NUM_SLV < 2^IDX_BITS.
- Without: slot NUM_SLV behaves as unmapped (ERR_DATA); no counters synthesised.

Test Plan:
- Read slot 1 (addr 32'h0300_1004), slave 1 ready 3 cycles after slv_valid with rdata 32'h1234_5678 -> slv_addr=12'h004, slv_valid=4'b0010 for 3 cycles, iomem_ready one cycle later, iomem_rdata=32'h1234_5678.
- Write slot 0 wstrb=4'b0011 wdata=32'hAABB_CCDD, slave ready immediately -> slv_wstrb=4'b0011, slv_wdata=32'hAABB_CCDD, iomem_ready at cycle 2.
- Read slot 2 with slv_ready held low, TIMEOUT=64 -> slv_valid drops, iomem_ready at cycle 65, rdata=32'hDEAD_BEEF; with macro, status read returns err_cnt=1, last_err_idx=2, timeout_seen=1.
- Access 32'h0300_9000 (slot 9, unmapped) -> iomem_ready at cycle 1, rdata=32'hDEAD_BEEF, no slv_valid.
- Access 32'h0400_0000 -> no iomem_ready, no slv_valid for 100 cycles.
- Deassert resetn while in REQ on slot 3 -> slv_valid=0, iomem_ready=0 immediately; after release, a fresh read of slot 3 completes normally.
